// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Steps each instruction through fetch, decode, execute, memory and writeback
// states from the 6-bit opcode. It drives every datapath enable and mux select,
// and produces the 2-bit ALUOp code for the ALU decoder.
// Every state that touches memory waits on mem_ready.
// Optional feature: define MC_CTRL_ADDI_J_EN to build the ADDI and J states.
// Without it, those opcodes decode as illegal.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_CTRL_ADDI_J_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  // ALUOp codes as seen by the ALU decoder; 2'b11 is never produced.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8
`ifdef MC_CTRL_ADDI_J_EN
    ,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
`endif
  } state_t;

  state_t state_q, state_d;

  // State register; a low rst_n at the edge aborts any instruction, memory waits included.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs; only FETCH's ir_write/pc_write follow mem_ready.
  always_comb begin
    state_d    = S_FETCH;
    alu_op     = ALUOP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALURES;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        // The PC+4 computation runs every cycle. PC and IR load only when the fetch completes.
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Precompute the branch target. The opcode is valid here because IR was loaded in FETCH.
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_ADDI_J_EN
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        // The opcode is sampled again here. If it is no longer a memory op, abandon the instruction.
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end

      S_MEMREAD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWRITE: begin
        // Hold the strobe for the whole access until memory accepts it.
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        // Compare the registers with SUB. The external zero flag qualifies the PC load from ALUOut.
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end

`ifdef MC_CTRL_ADDI_J_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
`endif

      default: begin
        // Unused encodings drive all outputs to 0 and recover to FETCH.
        state_d = S_FETCH;
      end
    endcase
  end

endmodule
